// File: rtl/mips_defs_pkg.sv
// Shared MIPS opcode/funct encodings and the Tuse/Tnew timing encoding
// used by the stall-side hazard logic.
package mips_defs_pkg;

    localparam logic [5:0] SPECIAL = 6'h00;
    localparam logic [5:0] JAL     = 6'h03;
    localparam logic [5:0] BEQ     = 6'h04;
    localparam logic [5:0] BNE     = 6'h05;
    localparam logic [5:0] ADDIU   = 6'h09;
    localparam logic [5:0] ORI     = 6'h0d;
    localparam logic [5:0] LUI     = 6'h0f;
    localparam logic [5:0] LW      = 6'h23;
    localparam logic [5:0] SW      = 6'h2b;

    localparam logic [5:0] JR      = 6'h08;
    localparam logic [5:0] MFHI    = 6'h10;
    localparam logic [5:0] MTHI    = 6'h11;
    localparam logic [5:0] MFLO    = 6'h12;
    localparam logic [5:0] MTLO    = 6'h13;
    localparam logic [5:0] MULT    = 6'h18;
    localparam logic [5:0] MULTU   = 6'h19;
    localparam logic [5:0] DIV     = 6'h1a;
    localparam logic [5:0] DIVU    = 6'h1b;
    localparam logic [5:0] ADDU    = 6'h21;
    localparam logic [5:0] SUBU    = 6'h23;

    typedef logic [1:0] timing_t;

    localparam timing_t T0        = 2'd0;
    localparam timing_t T1        = 2'd1;
    localparam timing_t T2        = 2'd2;
    localparam timing_t TUSE_NONE = 2'd3;

    function automatic logic funct_is_mdu_start(input logic [5:0] funct);
        return (funct == MULT) || (funct == MULTU) || (funct == DIV) || (funct == DIVU);
    endfunction

endpackage

// File: rtl/instr_timing_decode.sv
// Decodes one instruction into its operand-use times, result-ready times,
// register-write flag and MDU classification.
module instr_timing_decode
    import mips_defs_pkg::*;
(
    input  logic [31:0] instr,
    output timing_t     tuse_rs,
    output timing_t     tuse_rt,
    output timing_t     tnew_e,
    output timing_t     tnew_m,
    output logic        reg_we,
    output logic        is_mdu,
    output logic        is_mdu_start,
    output logic        mdu_is_div
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [19:0] instr_unused;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign instr_unused = instr[25:6];

    always_comb begin
        tuse_rs      = TUSE_NONE;
        tuse_rt      = TUSE_NONE;
        tnew_e       = T0;
        tnew_m       = T0;
        reg_we       = 1'b0;
        is_mdu       = 1'b0;
        is_mdu_start = 1'b0;
        mdu_is_div   = 1'b0;
        case (op)
            SPECIAL: begin
                case (funct)
                    ADDU, SUBU: begin
                        tuse_rs = T1;
                        tuse_rt = T1;
                        tnew_e  = T1;
                        reg_we  = 1'b1;
                    end
                    JR: tuse_rs = T0;
                    MULT, MULTU, DIV, DIVU: begin
                        tuse_rs      = T1;
                        tuse_rt      = T1;
                        is_mdu       = 1'b1;
                        is_mdu_start = funct_is_mdu_start(funct);
                        mdu_is_div   = (funct == DIV) || (funct == DIVU);
                    end
                    MTHI, MTLO: begin
                        tuse_rs = T1;
                        is_mdu  = 1'b1;
                    end
                    MFHI, MFLO: begin
                        tnew_e = T1;
                        reg_we = 1'b1;
                        is_mdu = 1'b1;
                    end
                    default: ;
                endcase
            end
            BEQ, BNE: begin
                tuse_rs = T0;
                tuse_rt = T0;
            end
            ADDIU, ORI: begin
                tuse_rs = T1;
                tnew_e  = T1;
                reg_we  = 1'b1;
            end
            LUI: begin
                tnew_e = T1;
                reg_we = 1'b1;
            end
            LW: begin
                tuse_rs = T1;
                tnew_e  = T2;
                tnew_m  = T1;
                reg_we  = 1'b1;
            end
            SW: begin
                tuse_rs = T1;
                tuse_rt = T2;
            end
            // jal writes $31 with the link address already known in E
            JAL: begin
                tnew_e = T0;
                reg_we = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall generator for the 5-stage core: Tuse/Tnew data-hazard stalls plus
// the MDU busy counter that holds MDU-class instructions in D.
module hazard_stall_unit
    import mips_defs_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      d_instr,
    input  logic [31:0]      e_instr,
    input  logic [31:0]      m_instr,
    input  logic [4:0]       e_a3,
    input  logic [4:0]       m_a3,
    output logic             stall,
    output logic             e_flush,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] mdu_cnt
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    timing_t d_tuse_rs;
    timing_t d_tuse_rt;
    logic    d_is_mdu;
    timing_t d_unused_tnew_e;
    timing_t d_unused_tnew_m;
    logic    d_unused_we;
    logic    d_unused_start;
    logic    d_unused_div;

    timing_t e_tnew;
    logic    e_we;
    logic    mdu_start;
    logic    e_is_div;
    timing_t e_unused_tuse_rs;
    timing_t e_unused_tuse_rt;
    timing_t e_unused_tnew_m;
    logic    e_unused_mdu;

    timing_t m_tnew;
    logic    m_we;
    timing_t m_unused_tuse_rs;
    timing_t m_unused_tuse_rt;
    timing_t m_unused_tnew_e;
    logic    m_unused_mdu;
    logic    m_unused_start;
    logic    m_unused_div;

    instr_timing_decode u_dec_d (
        .instr        (d_instr),
        .tuse_rs      (d_tuse_rs),
        .tuse_rt      (d_tuse_rt),
        .tnew_e       (d_unused_tnew_e),
        .tnew_m       (d_unused_tnew_m),
        .reg_we       (d_unused_we),
        .is_mdu       (d_is_mdu),
        .is_mdu_start (d_unused_start),
        .mdu_is_div   (d_unused_div)
    );

    instr_timing_decode u_dec_e (
        .instr        (e_instr),
        .tuse_rs      (e_unused_tuse_rs),
        .tuse_rt      (e_unused_tuse_rt),
        .tnew_e       (e_tnew),
        .tnew_m       (e_unused_tnew_m),
        .reg_we       (e_we),
        .is_mdu       (e_unused_mdu),
        .is_mdu_start (mdu_start),
        .mdu_is_div   (e_is_div)
    );

    instr_timing_decode u_dec_m (
        .instr        (m_instr),
        .tuse_rs      (m_unused_tuse_rs),
        .tuse_rt      (m_unused_tuse_rt),
        .tnew_e       (m_unused_tnew_e),
        .tnew_m       (m_tnew),
        .reg_we       (m_we),
        .is_mdu       (m_unused_mdu),
        .is_mdu_start (m_unused_start),
        .mdu_is_div   (m_unused_div)
    );

    logic [4:0] src      [2];
    timing_t    tuse_src [2];
    logic [1:0] src_hit;

    assign src[0]      = d_instr[25:21];
    assign src[1]      = d_instr[20:16];
    assign tuse_src[0] = d_tuse_rs;
    assign tuse_src[1] = d_tuse_rt;

    // A source stalls only when its producer's result arrives after D needs it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = (src[gi] != 5'd0) &&
                (((src[gi] == e_a3) && e_we && (tuse_src[gi] < e_tnew)) ||
                 ((src[gi] == m_a3) && m_we && (tuse_src[gi] < m_tnew)));
        end
    endgenerate

    logic [CNT_W-1:0] mdu_cnt_reg;
    logic [CNT_W-1:0] mdu_cnt_next;

    always_comb begin
        mdu_cnt_next = mdu_cnt_reg;
        if (mdu_start) begin
            mdu_cnt_next = e_is_div ? DIV_LOAD : MULT_LOAD;
        end else if (mdu_cnt_reg != '0) begin
            mdu_cnt_next = mdu_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdu_cnt_reg <= '0;
        end else begin
            mdu_cnt_reg <= mdu_cnt_next;
        end
    end

    logic stall_data;
    logic stall_mdu;

    assign stall_data = |src_hit;
    assign stall_mdu  = d_is_mdu && (mdu_busy || mdu_start);

    assign mdu_cnt  = mdu_cnt_reg;
    assign mdu_busy = (mdu_cnt_reg != '0);
    // Reset also masks the combinational stall so nothing freezes during reset.
    assign stall    = reset && (stall_data || stall_mdu);
    assign e_flush  = stall;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-step bench for hazard_stall_unit; expectations are queued as
// each step is driven and compared when the outputs are sampled.
module tb_hazard_stall_unit;
    import mips_defs_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] d_instr;
    logic [31:0] e_instr;
    logic [31:0] m_instr;
    logic [4:0]  e_a3;
    logic [4:0]  m_a3;
    logic        stall;
    logic        e_flush;
    logic        mdu_busy;
    logic [3:0]  mdu_cnt;

    hazard_stall_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .d_instr  (d_instr),
        .e_instr  (e_instr),
        .m_instr  (m_instr),
        .e_a3     (e_a3),
        .m_a3     (m_a3),
        .stall    (stall),
        .e_flush  (e_flush),
        .mdu_busy (mdu_busy),
        .mdu_cnt  (mdu_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       s;
        logic       b;
        logic [3:0] c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {SPECIAL, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic push_exp(input string tag, input logic s, input logic b, input logic [3:0] c);
        exp_t e;
        e.tag = tag;
        e.s   = s;
        e.b   = b;
        e.c   = c;
        q.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=stall%0d expected=queued_entry", stall);
            return;
        end
        e = q.pop_front();
        $display("step %s: stall=%0d e_flush=%0d busy=%0d cnt=%0d (exp %0d/%0d/%0d)",
                 e.tag, stall, e_flush, mdu_busy, mdu_cnt, e.s, e.b, e.c);
        total++;
        assert (stall === e.s) else begin
            bad++;
            $error("FAIL %s.stall observed=%0d expected=%0d", e.tag, stall, e.s);
        end
        total++;
        assert (e_flush === e.s) else begin
            bad++;
            $error("FAIL %s.e_flush observed=%0d expected=%0d", e.tag, e_flush, e.s);
        end
        total++;
        assert (mdu_busy === e.b) else begin
            bad++;
            $error("FAIL %s.mdu_busy observed=%0d expected=%0d", e.tag, mdu_busy, e.b);
        end
        total++;
        assert (mdu_cnt === e.c) else begin
            bad++;
            $error("FAIL %s.mdu_cnt observed=%0d expected=%0d", e.tag, mdu_cnt, e.c);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] d, input logic [31:0] e,
                        input logic [31:0] m, input logic [4:0] ea3, input logic [4:0] ma3,
                        input logic xs, input logic xb, input logic [3:0] xc);
        @(posedge clk);
        #1;
        d_instr = d;
        e_instr = e;
        m_instr = m;
        e_a3    = ea3;
        m_a3    = ma3;
        push_exp(tag, xs, xb, xc);
        @(negedge clk);
        check_now();
    endtask

    logic [31:0] lw1, lw0, addu_dep, addu1, beq12, addu00, sw1, mult45, div45, mflo6, nop;

    initial begin
        nop      = 32'h0;
        lw1      = i_type(LW, 5'd4, 5'd1, 16'd0);
        lw0      = i_type(LW, 5'd4, 5'd0, 16'd0);
        addu_dep = r_type(5'd1, 5'd3, 5'd2, ADDU);
        addu1    = r_type(5'd7, 5'd8, 5'd1, ADDU);
        beq12    = i_type(BEQ, 5'd1, 5'd2, 16'd4);
        addu00   = r_type(5'd0, 5'd0, 5'd2, ADDU);
        sw1      = i_type(SW, 5'd4, 5'd1, 16'd0);
        mult45   = r_type(5'd4, 5'd5, 5'd0, MULT);
        div45    = r_type(5'd4, 5'd5, 5'd0, DIV);
        mflo6    = r_type(5'd0, 5'd0, 5'd6, MFLO);

        // Reset with an MDU hazard present: stall must stay masked, counter held at 0.
        reset   = 1'b0;
        d_instr = mflo6;
        e_instr = mult45;
        m_instr = nop;
        e_a3    = 5'd0;
        m_a3    = 5'd0;
        #3;
        push_exp("reset_initial", 1'b0, 1'b0, 4'd0);
        check_now();
        @(negedge clk);
        push_exp("reset_held_edge", 1'b0, 1'b0, 4'd0);
        check_now();
        e_instr = nop;
        d_instr = nop;
        @(negedge clk);
        reset = 1'b1;

        // Load-use: lw in E, consumer in D; then lw in M resolves by forwarding.
        step("lw_use_e",   addu_dep, lw1, nop, 5'd1, 5'd0, 1'b1, 1'b0, 4'd0);
        step("lw_use_m",   addu_dep, nop, lw1, 5'd0, 5'd1, 1'b0, 1'b0, 4'd0);
        step("lw_m_beq",   beq12,    nop, lw1, 5'd0, 5'd1, 1'b1, 1'b0, 4'd0);
        // ALU result feeding a branch (Tuse 0).
        step("alu_beq_e",  beq12,    addu1, nop, 5'd1, 5'd0, 1'b1, 1'b0, 4'd0);
        step("alu_beq_m",  beq12,    nop, addu1, 5'd0, 5'd1, 1'b0, 1'b0, 4'd0);
        step("beq_rt_e",   i_type(BEQ, 5'd2, 5'd1, 16'd0), addu1, nop, 5'd1, 5'd0, 1'b1, 1'b0, 4'd0);
        // $0 never stalls; sw data (Tuse 2) meets lw Tnew 2.
        step("reg0",       addu00,   lw0, nop, 5'd0, 5'd0, 1'b0, 1'b0, 4'd0);
        step("sw_data",    sw1,      lw1, nop, 5'd1, 5'd0, 1'b0, 1'b0, 4'd0);
        step("sw_base",    i_type(SW, 5'd1, 5'd9, 16'd0), lw1, nop, 5'd1, 5'd0, 1'b1, 1'b0, 4'd0);
        step("idle",       nop,      nop, nop, 5'd0, 5'd0, 1'b0, 1'b0, 4'd0);

        // mult enters E at t with mflo in D; stall through t+5.
        step("mult_t0",    mflo6,    mult45, nop, 5'd0, 5'd0, 1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 6; k++) begin
            step($sformatf("mult_t%0d", k), mflo6, nop, nop, 5'd0, 5'd0,
                 (k <= 5), (k <= 5), 4'(6 - k));
        end

        // Reload while busy, then div and asynchronous reset at count 7.
        step("div_t0",     nop,      div45, nop, 5'd0, 5'd0, 1'b0, 1'b0, 4'd0);
        step("div_t1",     nop,      nop, nop, 5'd0, 5'd0, 1'b0, 1'b1, 4'd10);
        step("reload",     nop,      mult45, nop, 5'd0, 5'd0, 1'b0, 1'b1, 4'd9);
        step("reload_t1",  nop,      div45, nop, 5'd0, 5'd0, 1'b0, 1'b1, 4'd5);
        for (int k = 1; k <= 4; k++) begin
            step($sformatf("div_cnt%0d", k), (k == 4) ? mflo6 : nop, nop, nop, 5'd0, 5'd0,
                 (k == 4), 1'b1, 4'(11 - k));
        end
        #1;
        reset = 1'b0;
        #1;
        push_exp("async_reset", 1'b0, 1'b0, 4'd0);
        check_now();
        @(negedge clk);
        reset = 1'b1;
        step("post_reset", mflo6, nop, nop, 5'd0, 5'd0, 1'b0, 1'b0, 4'd0);

        // MDU idle with a non-MDU instruction in E: no stall for 20 cycles.
        for (int k = 0; k < 20; k++) begin
            step($sformatf("idle_mflo%0d", k), mflo6, addu1, nop, 5'd1, 5'd0, 1'b0, 1'b0, 4'd0);
        end

        if (q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall-side companion to the pipeline forwarding network in the 5-stage MIPS core.
- Decides when a D-stage consumer cannot be satisfied by forwarding, using Tuse/Tnew comparison.
- Owns the multiply/divide unit (MDU) busy counter and stalls MDU-class instructions while the MDU is occupied.
- Outputs freeze PC and the F/D register, and insert a bubble into D/E.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu enters E
- DIV_CYCLES, 10, busy cycles after div/divu enters E
- CNT_W, 4, MDU counter width; must hold DIV_CYCLES

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- d_instr  input  32  instruction in D
- e_instr  input  32  instruction in E
- m_instr  input  32  instruction in M
- e_a3  input  5  destination register of E instruction
- m_a3  input  5  destination register of M instruction
- stall  output  1  freeze PC and F/D; also the D/E flush request
- e_flush  output  1  clear D/E next edge; equal to stall
- mdu_busy  output  1  MDU counter nonzero
- mdu_cnt  output  CNT_W  remaining MDU busy cycles

Behaviour:
- Reset, while reset=0 (asynchronous): mdu_cnt=0, mdu_busy=0; stall and e_flush are forced to 0.
- Tuse values, decoded from d_instr:
  - rs: beq/bne/jr = 0; ALU R-type, I-type ALU, lw, sw = 1; MDU-class reading rs = 1.
  - rt: beq/bne = 0; R-type ALU and mult/div = 1; sw = 2.
  - Unused field: Tuse = 3 (never stalls).
- Tnew values:
  - Decoded per stage from e_instr and m_instr.
  - E stage: lw = 2; ALU, lui, mfhi/mflo = 1; jal = 0.
  - M stage: lw = 1; everything else = 0.
  - Instructions that write no register have no Tnew.
- Data stall condition, evaluated for each source register field (rs, rt):
  - stall_data = (src != 0) && (src == e_a3) && E writes a register && Tuse < TnewE;
  - OR the same test against m_a3, M-stage write, and TnewM.
- MDU start:
  - mdu_start = e_instr is mult/multu/div/divu. E is never held, so each start lasts exactly one cycle.
  - At the posedge with mdu_start: mdu_cnt loads MULT_CYCLES or DIV_CYCLES.
  - Otherwise, if mdu_cnt != 0, mdu_cnt decrements by 1. It saturates at 0 and never wraps.
- mdu_busy = (mdu_cnt != 0), registered-derived, no combinational path from e_instr.
- MDU stall:
  - stall_mdu = d_instr is MDU-class (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) && (mdu_busy || mdu_start).
- Output: stall = stall_data | stall_mdu, combinational, same cycle.
- Simultaneous data and MDU stall: a single stall; there is no priority issue.
- A new mdu_start while busy is impossible, because a stalled D blocks it. If it nonetheless occurs, the counter reloads.
- Reset asserted mid-count: counter clears immediately. After release, counting restarts only on a new mdu_start.

Decomposition:
- Shared package (mips_defs_pkg):
  - opcode and funct localparams (LW, SW, BEQ, BNE, LUI, JAL, SPECIAL; funct ADDU, SUBU, JR, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO);
  - 2-bit Tuse/Tnew encoding and the TUSE_NONE = 3 constant.
- Sub-module instr_timing_decode, instantiated three times (D, E, M):
  - inputs: instr;
  - outputs: tuse_rs, tuse_rt, tnew_e, tnew_m, reg_we, is_mdu, is_mdu_start, mdu_is_div.

Test Plan:
- lw $1 in E (e_a3=1), addu $2,$1,$3 in D -> stall=1 and e_flush=1 that cycle. Next cycle lw in M (m_a3=1) -> stall=0.
- addu $1 in E, beq $1,$2 in D -> stall=1. Next cycle addu in M -> stall=0.
- lw $0 in E, addu $2,$0,$0 in D -> stall=0. sw $1 in D with lw $1 in E -> stall=0 (Tuse 2 = Tnew 2).
- mult in E at cycle t, mflo in D:
  - stall=1 for cycles t through t+5; stall=0 at t+6;
  - mdu_cnt reads 5,4,3,2,1,0 from t+1.
- div in E, reset pulled low when mdu_cnt=7 -> mdu_cnt=0, mdu_busy=0, stall=0 immediately, without waiting for clk.
- mflo in D with MDU idle and a non-MDU instruction in E -> stall=0; mdu_cnt stays 0 across 20 cycles.
